// File: rtl/wb_regfile_pkg.sv
// wb_regfile shared definitions: MIPS opcode/function constants,
// write-back select encodings and instruction field helpers.
package wb_regfile_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_ADDU    = 6'h21;

    localparam logic [4:0] RI_BLTZ    = 5'h00;
    localparam logic [4:0] RI_BGEZ    = 5'h01;
    localparam logic [4:0] RI_BLTZAL  = 5'h10;
    localparam logic [4:0] RI_BGEZAL  = 5'h11;

    localparam logic [2:0] SEL_WB_ALU  = 3'd1;
    localparam logic [2:0] SEL_WB_LOAD = 3'd2;
    localparam logic [2:0] SEL_WB_LINK = 3'd4;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef struct packed {
        logic       we;
        logic [4:0] addr;
    } dest_t;

    function automatic logic [5:0] f_op(input logic [31:0] i);
        return i[31:26];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] i);
        return i[20:16];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] i);
        return i[15:11];
    endfunction

    function automatic logic [5:0] f_funct(input logic [31:0] i);
        return i[5:0];
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// Stage-5 to write-back bundle plus decode read ports and
// commit observability signals.
interface wb_regfile_if;

    logic [31:0] I4;
    logic        valid4;
    logic [2:0]  WBsel;
    logic [31:0] alu4;
    logic [31:0] lmdr4;
    logic [31:0] link4;
    logic [4:0]  raddr_a;
    logic [4:0]  raddr_b;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    modport master (
        output I4, valid4, WBsel, alu4, lmdr4, link4,
        output raddr_a, raddr_b,
        input  rdata_a, rdata_b,
        input  wr_en, wr_addr, wr_data
    );

    modport slave (
        input  I4, valid4, WBsel, alu4, lmdr4, link4,
        input  raddr_a, raddr_b,
        output rdata_a, rdata_b,
        output wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/wb_regfile_load_align.sv
// Big-endian load alignment: picks the addressed byte/halfword
// out of the raw cache word and sign- or zero-extends it.
module wb_regfile_load_align
    import wb_regfile_pkg::*;
(
    input  logic [31:0] i_lmdr,
    input  logic [1:0]  i_off,
    input  logic [5:0]  i_op,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select byte/halfword lanes; offset 0 is the most significant byte.
    always_comb begin
        w_byte = i_lmdr[31:24];
        case (i_off)
            2'd1:    w_byte = i_lmdr[23:16];
            2'd2:    w_byte = i_lmdr[15:8];
            2'd3:    w_byte = i_lmdr[7:0];
            default: w_byte = i_lmdr[31:24];
        endcase
        w_half = i_off[1] ? i_lmdr[15:0] : i_lmdr[31:16];
    end

    // Extend by load type; LW and anything else pass the word through.
    always_comb begin
        o_data = i_lmdr;
        case (i_op)
            OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_data = {24'd0, w_byte};
            OP_LH:   o_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_data = {16'd0, w_half};
            default: o_data = i_lmdr;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back commit and architectural register file: destination
// decode, result mux, 32x32 array with write-through, retire counter.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int CNTW  = 32
) (
    input  logic            clk,
    input  logic            reset,
    wb_regfile_if.slave     bus,
    output logic [CNTW-1:0] o_retired
);

    logic [31:0]     r_regs [NREGS];
    logic [CNTW-1:0] r_retired;

    dest_t       w_dest;
    logic [5:0]  w_op;
    logic [4:0]  w_rt;
    logic [31:0] w_load;
    logic [31:0] w_data;
    logic        w_we;

    assign w_op = f_op(bus.I4);
    assign w_rt = f_rt(bus.I4);

    wb_regfile_load_align u_align (
        .i_lmdr (bus.lmdr4),
        .i_off  (bus.alu4[1:0]),
        .i_op   (w_op),
        .o_data (w_load)
    );

    // Destination decode: which opcodes write, and to which register.
    always_comb begin
        w_dest = '0;
        case (w_op)
            OP_SPECIAL: begin
                w_dest.we   = (f_funct(bus.I4) != FN_JR);
                w_dest.addr = f_rd(bus.I4);
            end
            OP_JAL: begin
                w_dest.we   = 1'b1;
                w_dest.addr = REG_RA;
            end
            OP_REGIMM: begin
                w_dest.we   = (w_rt == RI_BGEZAL) ||
                              (w_rt == RI_BLTZAL);
                w_dest.addr = REG_RA;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                w_dest.we   = 1'b1;
                w_dest.addr = w_rt;
            end
            default: w_dest = '0;
        endcase
    end

    // Result source mux; unlisted selects fall back to the ALU.
    always_comb begin
        w_data = bus.alu4;
        case (bus.WBsel)
            SEL_WB_LOAD: w_data = w_load;
            SEL_WB_LINK: w_data = bus.link4;
            default:     w_data = bus.alu4;
        endcase
    end

    assign w_we = bus.valid4 && w_dest.we && (w_dest.addr != 5'd0);

    assign bus.wr_en   = w_we;
    assign bus.wr_addr = w_dest.addr;
    assign bus.wr_data = w_data;

    // Read port A: r0 is zero, a matching commit is forwarded.
    always_comb begin
        bus.rdata_a = r_regs[bus.raddr_a];
        if (bus.raddr_a == 5'd0)
            bus.rdata_a = '0;
        else if (w_we && (w_dest.addr == bus.raddr_a))
            bus.rdata_a = w_data;
    end

    // Read port B: same rules as port A.
    always_comb begin
        bus.rdata_b = r_regs[bus.raddr_b];
        if (bus.raddr_b == 5'd0)
            bus.rdata_b = '0;
        else if (w_we && (w_dest.addr == bus.raddr_b))
            bus.rdata_b = w_data;
    end

    // Array commit; reset clears everything and drops the commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else if (w_we) begin
            r_regs[w_dest.addr] <= w_data;
        end
    end

    // Retire counter counts every valid stage-5 slot, wrapping.
    always_ff @(posedge clk) begin
        if (reset)
            r_retired <= '0;
        else if (bus.valid4)
            r_retired <= r_retired + 1'b1;
    end

    assign o_retired = r_retired;

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back commit unit and architectural register file for the minicpu MIPS pipeline. It consumes the stage-5 instruction and its `WBsel` write-back select, and chooses the result source: ALU, aligned and extended load data, or link PC. It also determines the destination register, commits the result to a 32×32 register file, and serves the decode stage's two read ports with same-cycle write-through. A retired-instruction counter is maintained for debug.

## Interface
- `NREGS`, 32: register count; r0 hardwired to zero.
- `CNTW`, 32: retire counter width.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `I4`  in  32  stage-5 instruction (`op`, `rt`, `rd`, `function` fields per `mips.h`).
- `valid4`  in  1  stage 5 holds a real instruction (0 = bubble/squashed).
- `WBsel`  in  3  result select: `select_wb_alu`, `select_wb_load`, `select_wb_link`.
- `alu4`  in  32  ALU result; bits [1:0] are the load byte offset.
- `lmdr4`  in  32  raw word returned by the data cache.
- `link4`  in  32  link PC for jal/jalr/bgezal/bltzal.
- `raddr_a`, `raddr_b`  in  5  decode read addresses.
- `rdata_a`, `rdata_b`  out  32  read data, combinational.
- `wr_en`, `wr_addr`, `wr_data`  out  1/5/32  commit observability, combinational for the current cycle.
- `retired`  out  `CNTW`  count of committed valid instructions.

## Operation
- Destination: `SPECIAL` → `rd`, except `JR`, which does not write; `JAL` → 31; `REGIMM` with `BGEZAL`/`BLTZAL` → 31; loads (LW, LH, LHU, LB, LBU) and ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI/LUI → `rt`. Every other opcode (stores, branches, J, unknown) does not write.
- `wr_en` = `valid4` & writes-opcode & (dest ≠ 0).
- Data mux: `WBsel` selects `alu4`, the load result, or `link4`. Any unlisted `WBsel` encoding selects `alu4`.
- Load alignment is big-endian. Offset 0 is `lmdr4[31:24]`.
  - LB/LBU: byte at `alu4[1:0]`, sign- or zero-extended.
  - LH/LHU: halfword at `alu4[1]`, with `alu4[0]` ignored, sign- or zero-extended.
  - LW: the full word, with `alu4[1:0]` ignored.
- Reads: address 0 returns 0. If `wr_en` is set and `wr_addr` equals a read address, that port returns `wr_data` in the same cycle (write-through). Otherwise the port returns array contents.
- `retired` increments by 1 on every cycle with `valid4`=1, including non-writing instructions. It wraps modulo 2^`CNTW`.

## Timing
- Commit: the array updates at the rising edge ending the cycle in which `wr_en`=1. Write-through makes the value visible to decode in that same cycle. Latency is 0 cycles to reads and 1 edge to storage.
- Reset: on any edge with `reset`=1, all registers and `retired` become 0 and no commit occurs, even if `wr_en` would be 1. During reset cycles, `rdata_*` show the pre-edge array plus write-through. From the first cycle after reset, all reads return 0.
- Reset mid-stream: the in-flight stage-5 instruction is dropped, and no partial state is retained.
- A write to r0 is silently discarded. Both read ports may hit the same address or the write address simultaneously.
- There is no stall input: a stage-5 instruction that must not commit is delivered with `valid4`=0.

## Structure
- Shared package / `mips.h`: opcode, `rt`, and function constants; `select_wb_*` encodings; field macros `op`, `rt`, `rd`, `function`.
- One natural sub-module, `load_align`, is combinational: inputs are `lmdr4`, offset, and op; output is the extended 32-bit load result.
- Top level holds the destination decode, data mux, register array, bypass, and counter.

## Test plan
- Reset, then read r0–r31 → all 0; `retired`=0.
- ADDIU r5 (`alu4`=0x1234, `WBsel`=alu), with decode reading r5 in the same cycle → `rdata_a`=0x1234 that cycle; r5 holds 0x1234 after the edge.
- LB with `lmdr4`=0x80FF7F01 at offsets 0–3 → 0xFFFFFF80, 0xFFFFFFFF, 0x0000007F, 0x00000001. LBU at offset 0 → 0x80. LH at offset 2 → 0x00007F01. LHU at offset 0 → 0x80FF.
- JAL with `link4`=0x400008 → r31=0x400008. JR → `wr_en`=0; `retired` still increments.
- SPECIAL ADDU with rd=0 and `alu4`=0xDEAD → `wr_en`=0; r0 reads 0. SW with `valid4`=1 → no write.
- Assert `reset` in the same cycle as a valid write to r7 → r7=0 afterwards and `retired`=0. Preload `retired`=2^`CNTW`−1, then retire one instruction → 0.
